nvme_ucq_sq: RTL and testbench
==============================

// Module: nvme_ucq_sq
// PURPOSE
//  Microcontroller-side NVMe submission queue, the write/issue counterpart of the ucq completion queue.
//  - The microcontroller assembles a 64B SQ entry dword-by-dword in a staging buffer over the ucontrol IO bus.
//  - It then commits the entry into queue RAM at the tail and rings a doorbell to the endpoint.
//  - The endpoint fetches entries through a 144b (128 data + 16 parity) read port.
//  - Head is advanced by the SQ-head field of completions.
// PARAMETERS
//  num_entries     4                          SQ depth; power of 2, >=2
//  sq_ptr_width    $clog2(num_entries)        head/tail pointer width
//  sq_rdwidth      128                        endpoint read data width (+sq_rdwidth/8 parity bits)
//  sq_num_words    num_entries*4              RAM words; one 64B entry = 4 words
//  sq_addr_width   $clog2(sq_num_words)       RAM address width
//  ioaddr_base     0                          IO window select; compared against ctl_sq_ioaddress[11:8]
// PORTS
//  clk                     in   1    clock
//  reset                   in   1    asynchronous, active-high reset
//  ctl_sq_ioaddress        in   32   IO byte address
//  ctl_sq_ioread_strobe    in   1    1-cycle read request
//  ctl_sq_iowrite_data     in   36   [35:32] odd byte parity, [31:0] data
//  ctl_sq_iowrite_strobe   in   1    1-cycle write request
//  sq_ctl_ioread_data      out  36   read data, valid when sq_ctl_ioack=1
//  sq_ctl_ioack            out  1    1-cycle ack
//  sq_reset                in   1    synchronous queue clear
//  sq_head                 in   sq_ptr_width   head value from completion entry
//  sq_head_update          in   1    load sq_head
//  sq_tail_out             out  sq_ptr_width   committed tail
//  sq_doorbell             out  1    1-cycle pulse when the tail advances
//  sq_empty                out  1    head==tail (registered)
//  sq_full                 out  1    head==tail+1 (registered)
//  sq_rdaddr               in   sq_addr_width  endpoint read address
//  sq_rddata               out  sq_rdwidth*9/8 registered read data
//  sq_perror               out  1    parity error pulse (PARCHK only)
// BEHAVIOUR
//  - Decode: window hit when ioaddress[11:7]=={ioaddr_base[3:0],1'b0}; misses are never acked.
//  - Offsets 0x00-0x3C STAGE[n], n=addr[5:2].
//    - Write stores the 36b word into stage[n]; read returns it.
//    - Ack is 1 cycle after the strobe.
//  - Offset 0x44 SQ_STATUS, read only.
//    - Data = {odd parity nibble, 28'b0, perr, ovf, sq_full, sq_empty}; ack is 1 cycle after the strobe.
//  - Offset 0x40 SQ_INSERT, write only. FSM IDLE->COPY->DONE->IDLE.
//    - Strobe at T with !full: COPY for T+1..T+4, writing RAM[{tail,k}] = {par of stage[4k+3..4k], data of stage[4k+3..4k]} for k=0..3.
//    - DONE at T+5: tail+=1 (wraps at num_entries), sq_doorbell=1, ioack=1.
//    - Strobe at T while full: no copy; sticky ovf set; ack at T+1.
//    - IO strobes while the FSM is not IDLE are ignored and not acked; the microcontroller never issues them.
//  - Write to an undefined in-window offset: acked at T+1, no effect. Reads of undefined offsets return 0 and are acked.
//  - Head:
//    - sq_head_update loads sq_head into head_q on the next edge.
//    - A head update and a tail advance in the same cycle both take effect.
//    - full/empty are recomputed from the new values.
//  - Endpoint read: sq_rddata = RAM[sq_rdaddr] one cycle later.
//    - A read of the word being written in the same cycle returns old data.
//  - sq_reset (sync):
//    - Clears head, tail, ovf and perr; FSM -> IDLE.
//    - Aborts an in-flight copy: partial RAM writes remain, no ack, no doorbell.
//    - Staging buffer is kept.
//  - Reset values: head=tail=0, FSM IDLE, sq_empty=1, sq_full=0, sq_doorbell=0, sq_ctl_ioack=0.
//    - Also reset: sq_ctl_ioread_data=0, sq_rddata=0, ovf=perr=0, sq_perror=0.
//    - Staging buffer and RAM are not reset.
// CONFIGURATION
//  NVME_UCQ_SQ_PARCHK_EN
//  - Defined:
//    - STAGE writes are checked for odd parity per byte.
//    - On mismatch: write dropped, still acked; sticky perr set; sq_perror pulses on the ack cycle.
//  - Undefined: parity is stored unchecked; perr reads 0; sq_perror is tied 0.
// TESTING
//  - Reset -> STATUS read returns data[3:0]=4'b0001; sq_doorbell=0; tail=0.
//  - Stage 16 dwords 0x1000_0000+n, then INSERT at T:
//    - ack at T+5, doorbell pulse, tail=1.
//    - sq_rdaddr=1 -> sq_rddata[127:0]=={0x10000007,0x10000006,0x10000005,0x10000004}.
//  - num_entries=4: three INSERTs -> full=1. Fourth INSERT -> ack at T+1, no doorbell, ovf=1, tail stays 3.
//  - Full queue with sq_head_update(head=2) in the same cycle as an INSERT completion -> both apply; full=0, empty=0.
//  - sq_reset at T+2 of an INSERT -> no ack, no doorbell, head=tail=0, empty=1.
//  - PARCHK_EN: STAGE write with bad parity nibble -> acked, sq_perror=1, stage unchanged, STATUS perr=1.

Source files
------------

// File: rtl/nvme_ucq_sq.sv
// rtl/nvme_ucq_sq.sv - microcontroller-side NVMe submission queue with staging buffer and endpoint read port
//
// Purpose:
//   The microcontroller writes a 64B SQ entry as 16 parity-protected dwords into
//   a staging buffer, then writes SQ_INSERT. The entry is copied into queue RAM at
//   the tail as four 144b words, the tail advances and a doorbell pulse is issued.
//   The endpoint reads queue RAM through a registered 144b port. The head follows
//   the SQ-head field of completions.
//
// IO map (window hit when ioaddress[11:7] == {ioaddr_base, 1'b0}):
//   0x00-0x3C STAGE[n]   read/write, n = addr[5:2]
//   0x40      SQ_INSERT  write only
//   0x44      SQ_STATUS  read only {par, 28'b0, perr, ovf, full, empty}
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_ctl_sq_*                     ucontrol IO bus request (address, strobes, write data)
//   o_sq_ctl_ioread_data/_ioack    IO response
//   i_sq_reset                     synchronous queue clear
//   i_sq_head, i_sq_head_update    head load from completion entries
//   o_sq_tail_out, o_sq_doorbell   committed tail and advance pulse
//   o_sq_empty, o_sq_full          registered queue state
//   i_sq_rdaddr, o_sq_rddata       endpoint read port, one-cycle latency
//   o_sq_perror                    staging write parity error pulse
//
// Configuration macro: NVME_UCQ_SQ_PARCHK_EN enables odd-parity checking of STAGE writes.

module nvme_ucq_sq #(
    parameter int         num_entries   = 4,
    parameter int         sq_rdwidth    = 128,
    parameter logic [3:0] ioaddr_base   = 4'd0,
    localparam int        sq_ptr_width  = $clog2(num_entries),
    localparam int        sq_num_words  = num_entries * 4,
    localparam int        sq_addr_width = $clog2(sq_num_words),
    localparam int        sq_ramwidth   = sq_rdwidth * 9 / 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [31:0]              i_ctl_sq_ioaddress,
    input  logic                     i_ctl_sq_ioread_strobe,
    input  logic [35:0]              i_ctl_sq_iowrite_data,
    input  logic                     i_ctl_sq_iowrite_strobe,
    output logic [35:0]              o_sq_ctl_ioread_data,
    output logic                     o_sq_ctl_ioack,
    input  logic                     i_sq_reset,
    input  logic [sq_ptr_width-1:0]  i_sq_head,
    input  logic                     i_sq_head_update,
    output logic [sq_ptr_width-1:0]  o_sq_tail_out,
    output logic                     o_sq_doorbell,
    output logic                     o_sq_empty,
    output logic                     o_sq_full,
    input  logic [sq_addr_width-1:0] i_sq_rdaddr,
    output logic [sq_ramwidth-1:0]   o_sq_rddata,
    output logic                     o_sq_perror
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COPY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OFF_INSERT = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h11;

    localparam logic [4:0]              lp_win     = {ioaddr_base, 1'b0};
    localparam logic [sq_ptr_width-1:0] lp_ptr_one = sq_ptr_width'(1);

    logic [35:0]              r_stage [0:15];
    logic [sq_ramwidth-1:0]   r_ram   [0:sq_num_words-1];

    logic [1:0]               r_state;
    logic [1:0]               r_k;
    logic [sq_ptr_width-1:0]  r_head;
    logic [sq_ptr_width-1:0]  r_tail;
    logic                     r_empty;
    logic                     r_full;
    logic                     r_ovf;
    logic                     r_perr;
    logic                     r_ioack;
    logic                     r_doorbell;
    logic                     r_perror;
    logic [35:0]              r_ioread_data;
    logic [sq_ramwidth-1:0]   r_rddata;

    logic                     w_hit;
    logic                     w_idle;
    logic                     w_wr;
    logic                     w_rd;
    logic [4:0]               w_off;
    logic                     w_stage_sel;
    logic                     w_par_bad;
    logic [31:0]              w_status;
    logic [35:0]              w_rd_data;
    logic [sq_ramwidth-1:0]   w_copy_word;
    logic                     w_tail_adv;
    logic [sq_ptr_width-1:0]  w_head_nxt;
    logic [sq_ptr_width-1:0]  w_tail_nxt;
    logic                     w_unused_addr;

    // Only address bits [11:2] take part in decode.
    assign w_unused_addr = ^{i_ctl_sq_ioaddress[31:12], i_ctl_sq_ioaddress[1:0]};

    assign w_off       = i_ctl_sq_ioaddress[6:2];
    assign w_stage_sel = !w_off[4];
    assign w_hit       = (i_ctl_sq_ioaddress[11:7] == lp_win);
    assign w_idle      = (r_state == S_IDLE);
    // Strobes are only honoured in IDLE; a queue clear also swallows a strobe.
    assign w_wr        = w_hit && i_ctl_sq_iowrite_strobe && w_idle && !i_sq_reset;
    assign w_rd        = w_hit && i_ctl_sq_ioread_strobe && !i_ctl_sq_iowrite_strobe
                         && w_idle && !i_sq_reset;

`ifdef NVME_UCQ_SQ_PARCHK_EN
    // Each byte plus its parity bit must carry an odd number of ones.
    always_comb begin
        w_par_bad = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (!(^{i_ctl_sq_iowrite_data[32+b], i_ctl_sq_iowrite_data[8*b +: 8]})) begin
                w_par_bad = 1'b1;
            end
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_status = {28'd0, r_perr, r_ovf, r_full, r_empty};

    always_comb begin
        w_rd_data = '0;
        if (w_stage_sel) begin
            w_rd_data = r_stage[w_off[3:0]];
        end else if (w_off == OFF_STATUS) begin
            w_rd_data[31:0] = w_status;
            for (int b = 0; b < 4; b++) begin
                w_rd_data[32+b] = ~^w_status[8*b +: 8];
            end
        end
    end

    // RAM word k of an entry: dwords 4k..4k+3 little-endian in the data field,
    // their parity nibbles in the same order above the data.
    always_comb begin
        w_copy_word = '0;
        for (int d = 0; d < 4; d++) begin
            w_copy_word[32*d +: 32]           = r_stage[{r_k, 2'(d)}][31:0];
            w_copy_word[sq_rdwidth + 4*d +: 4] = r_stage[{r_k, 2'(d)}][35:32];
        end
    end

    // Tail advances on the edge that writes the last word, so DONE shows the new tail.
    assign w_tail_adv = (r_state == S_COPY) && (r_k == 2'd3);
    assign w_head_nxt = i_sq_reset ? '0 : (i_sq_head_update ? i_sq_head : r_head);
    assign w_tail_nxt = i_sq_reset ? '0 : (w_tail_adv ? r_tail + lp_ptr_one : r_tail);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_k           <= 2'd0;
            r_head        <= '0;
            r_tail        <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_ovf         <= 1'b0;
            r_perr        <= 1'b0;
            r_ioack       <= 1'b0;
            r_doorbell    <= 1'b0;
            r_perror      <= 1'b0;
            r_ioread_data <= '0;
        end else begin
            r_ioack    <= 1'b0;
            r_doorbell <= 1'b0;
            r_perror   <= 1'b0;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_empty    <= (w_head_nxt == w_tail_nxt);
            r_full     <= (w_head_nxt == w_tail_nxt + lp_ptr_one);
            if (i_sq_reset) begin
                r_state <= S_IDLE;
                r_k     <= 2'd0;
                r_ovf   <= 1'b0;
                r_perr  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_wr) begin
                            if (w_off == OFF_INSERT) begin
                                if (r_full) begin
                                    r_ovf   <= 1'b1;
                                    r_ioack <= 1'b1;
                                end else begin
                                    r_state <= S_COPY;
                                    r_k     <= 2'd0;
                                end
                            end else begin
                                r_ioack <= 1'b1;
                                if (w_stage_sel && w_par_bad) begin
                                    r_perr   <= 1'b1;
                                    r_perror <= 1'b1;
                                end
                            end
                        end else if (w_rd) begin
                            r_ioack       <= 1'b1;
                            r_ioread_data <= w_rd_data;
                        end
                    end
                    S_COPY: begin
                        r_k <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            r_state    <= S_DONE;
                            r_ioack    <= 1'b1;
                            r_doorbell <= 1'b1;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Staging buffer and queue RAM carry no reset.
    always_ff @(posedge i_clk) begin
        if (w_wr && w_stage_sel && !w_par_bad) begin
            r_stage[w_off[3:0]] <= i_ctl_sq_iowrite_data;
        end
        if ((r_state == S_COPY) && !i_sq_reset) begin
            r_ram[{r_tail, r_k}] <= w_copy_word;
        end
    end

    // Read-before-write: a same-cycle write to the addressed word returns old data.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rddata <= '0;
        end else begin
            r_rddata <= r_ram[i_sq_rdaddr];
        end
    end

    assign o_sq_ctl_ioread_data = r_ioread_data;
    assign o_sq_ctl_ioack       = r_ioack;
    assign o_sq_tail_out        = r_tail;
    assign o_sq_doorbell        = r_doorbell;
    assign o_sq_empty           = r_empty;
    assign o_sq_full            = r_full;
    assign o_sq_rddata          = r_rddata;
    assign o_sq_perror          = r_perror;

endmodule

// File: tb/tb_nvme_ucq_sq.sv
// tb/tb_nvme_ucq_sq.sv - scoreboard bench for nvme_ucq_sq
module tb_nvme_ucq_sq;
    localparam int NE = 4;
    localparam int NW = NE * 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  ioaddr = '0;
    logic         iord = 1'b0;
    logic [35:0]  iowdata = '0;
    logic         iowr = 1'b0;
    logic [35:0]  iordata;
    logic         ioack;
    logic         sqrst = 1'b0;
    logic [1:0]   head_in = '0;
    logic         head_upd = 1'b0;
    logic [1:0]   tail_out;
    logic         db;
    logic         empty;
    logic         full;
    logic [3:0]   rdaddr = '0;
    logic [143:0] rddata;
    logic         perror;

    nvme_ucq_sq #(.num_entries(NE)) dut (
        .i_clk                   (clk),
        .i_reset                 (rst),
        .i_ctl_sq_ioaddress      (ioaddr),
        .i_ctl_sq_ioread_strobe  (iord),
        .i_ctl_sq_iowrite_data   (iowdata),
        .i_ctl_sq_iowrite_strobe (iowr),
        .o_sq_ctl_ioread_data    (iordata),
        .o_sq_ctl_ioack          (ioack),
        .i_sq_reset              (sqrst),
        .i_sq_head               (head_in),
        .i_sq_head_update        (head_upd),
        .o_sq_tail_out           (tail_out),
        .o_sq_doorbell           (db),
        .o_sq_empty              (empty),
        .o_sq_full               (full),
        .i_sq_rdaddr             (rdaddr),
        .o_sq_rddata             (rddata),
        .o_sq_perror             (perror)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [35:0] data;
        bit          chk_data;
        bit          db;
        bit          pe;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   n_ack  = 0;

    // Reference model: queue as head/tail counters, RAM as entry words.
    logic [35:0]  m_stage [16];
    logic [143:0] m_mem   [NW];
    bit           m_val   [NW];
    int           m_head = 0;
    int           m_tail = 0;
    bit           m_ovf  = 0;
    bit           m_perr = 0;

    task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    function automatic logic [3:0] par4(input logic [31:0] d);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) p[b] = ~^d[8*b +: 8];
        return p;
    endfunction

    function automatic int m_count();
        return (m_tail - m_head + NE) % NE;
    endfunction

    function automatic logic [35:0] m_status();
        logic [31:0] s;
        s = {28'd0, m_perr, m_ovf, m_count() == NE - 1, m_count() == 0};
        return {par4(s), s};
    endfunction

    task automatic m_insert();
        for (int k = 0; k < 4; k++) begin
            logic [143:0] w;
            for (int d = 0; d < 4; d++) begin
                w[32*d +: 32]    = m_stage[4*k + d][31:0];
                w[128 + 4*d +: 4] = m_stage[4*k + d][35:32];
            end
            m_mem[m_tail*4 + k] = w;
            m_val[m_tail*4 + k] = 1'b1;
        end
        m_tail = (m_tail + 1) % NE;
    endtask

    // Monitor: every ack pops one expectation; pulses without ack are errors.
    always @(negedge clk) begin
        if (!rst && (ioack || db || perror)) begin
            if (!ioack) begin
                check("unsolicited_pulse", {db, perror}, 2'b00);
            end else begin
                n_ack++;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_cycle", cyc, e.due);
                    if (e.chk_data) check("ioread_data", iordata, e.data);
                    check("doorbell", db, e.db);
                    check("perror", perror, e.pe);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            check("ack_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic io_op(input bit wr, input logic [31:0] addr, input logic [35:0] wd);
        exp_t       e;
        int         n0;
        bit         hit;
        logic [4:0] off;
        @(posedge clk); #1;
        hit = (addr[11:7] == 5'b0);
        off = addr[6:2];
        e.due = cyc + 1; e.data = '0; e.chk_data = 1'b0; e.db = 1'b0; e.pe = 1'b0;
        n0 = n_ack;
        if (hit) begin
            if (wr) begin
                if (!off[4]) begin
`ifdef NVME_UCQ_SQ_PARCHK_EN
                    if (par4(wd[31:0]) != wd[35:32]) begin
                        m_perr = 1'b1;
                        e.pe = 1'b1;
                    end else begin
                        m_stage[off[3:0]] = wd;
                    end
`else
                    m_stage[off[3:0]] = wd;
`endif
                end else if (off == 5'h10) begin
                    if (m_count() == NE - 1) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_insert();
                        e.due = cyc + 5;
                        e.db = 1'b1;
                    end
                end
            end else begin
                e.chk_data = 1'b1;
                if (!off[4]) e.data = m_stage[off[3:0]];
                else if (off == 5'h11) e.data = m_status();
            end
            exp_q.push_back(e);
        end
        ioaddr = addr; iowdata = wd; iowr = wr; iord = !wr;
        @(posedge clk); #1;
        iowr = 1'b0; iord = 1'b0;
        if (hit) begin
            drain();
        end else begin
            repeat (6) @(posedge clk);
            check("miss_no_ack", n_ack, n0);
        end
    endtask

    task automatic head_update(input int h);
        @(posedge clk); #1;
        head_in = h[1:0]; head_upd = 1'b1;
        @(posedge clk); #1;
        head_upd = 1'b0;
        m_head = h;
    endtask

    // INSERT with a head update landing on the same edge as the tail advance.
    task automatic insert_head(input int h);
        exp_t e;
        @(posedge clk); #1;
        e.due = cyc + 5; e.data = '0; e.chk_data = 1'b0; e.db = 1'b1; e.pe = 1'b0;
        m_insert();
        exp_q.push_back(e);
        ioaddr = 32'h40; iowr = 1'b1;
        @(posedge clk); #1;
        iowr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        head_in = h[1:0]; head_upd = 1'b1;
        @(posedge clk); #1;
        head_upd = 1'b0;
        m_head = h;
        drain();
    endtask

    // INSERT aborted by sq_reset two cycles after the strobe cycle.
    task automatic insert_abort();
        int n0;
        n0 = n_ack;
        @(posedge clk); #1;
        ioaddr = 32'h40; iowr = 1'b1;
        @(posedge clk); #1;
        iowr = 1'b0;
        @(posedge clk); #1;
        sqrst = 1'b1;
        @(posedge clk); #1;
        sqrst = 1'b0;
        for (int k = 0; k < 4; k++) m_val[m_tail*4 + k] = 1'b0;
        m_head = 0; m_tail = 0; m_ovf = 1'b0; m_perr = 1'b0;
        repeat (8) @(posedge clk);
        check("abort_no_ack", n_ack, n0);
    endtask

    task automatic chk_ptrs();
        @(negedge clk);
        check("tail", tail_out, m_tail[1:0]);
        check("empty", empty, m_count() == 0);
        check("full", full, m_count() == NE - 1);
    endtask

    task automatic ep_check(input int w);
        @(posedge clk); #1;
        rdaddr = w[3:0];
        @(posedge clk);
        @(negedge clk);
        if (m_val[w]) check("ep_rddata", rddata, m_mem[w]);
    endtask

    function automatic logic [35:0] good_word(input logic [31:0] d);
        return {par4(d), d};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NW; i++) m_val[i] = 1'b0;
        for (int i = 0; i < 16; i++) m_stage[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ioack", ioack, 0);
        check("rst_doorbell", db, 0);
        check("rst_tail", tail_out, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ioread_data", iordata, 0);
        check("rst_rddata", rddata, 0);
        check("rst_perror", perror, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        io_op(0, 32'h44, '0);
        check("tc_status_lsbs", iordata[3:0], 4'b0001);

        for (int n = 0; n < 16; n++) io_op(1, 32'(n * 4), good_word(32'h1000_0000 + 32'(n)));
        io_op(1, 32'h40, '0);
        chk_ptrs();
        check("tc_tail1", tail_out, 1);
        ep_check(1);
        check("tc_word1", rddata[127:0], 128'h10000007_10000006_10000005_10000004);

        io_op(1, 32'h40, '0);
        io_op(1, 32'h40, '0);
        chk_ptrs();
        check("tc_full", full, 1);
        io_op(1, 32'h40, '0);
        chk_ptrs();
        check("tc_ovf_tail", tail_out, 3);
        io_op(0, 32'h44, '0);
        check("tc_ovf", iordata[2], 1);

        head_update(1);
        chk_ptrs();
        insert_head(2);
        chk_ptrs();
        check("tc_both_full", full, 0);
        check("tc_both_empty", empty, 0);
        ep_check(12);
        ep_check(15);

        insert_abort();
        chk_ptrs();
        check("tc_abort_tail", tail_out, 0);
        check("tc_abort_empty", empty, 1);
        io_op(0, 32'h44, '0);

        io_op(1, 32'h14, good_word(32'hA5A5_1234) ^ 36'h1_0000_0000);
        io_op(0, 32'h14, '0);
        io_op(0, 32'h44, '0);
`ifdef NVME_UCQ_SQ_PARCHK_EN
        check("tc_perr", iordata[3], 1);
`endif

        io_op(1, 32'h48, good_word(32'hDEAD_BEEF));
        io_op(0, 32'h48, '0);
        io_op(0, 32'h40, '0);
        io_op(1, 32'h44, good_word(32'h0000_000F));
        io_op(0, 32'h44, '0);
        io_op(0, 32'h0000_0180, '0);
        io_op(1, 32'h0000_0F00, good_word(32'h1));

        for (int it = 0; it < 150; it++) begin
            int          op;
            logic [31:0] d;
            logic [31:0] up;
            op = $urandom_range(0, 9);
            d  = $urandom;
            up = $urandom & 32'hFFFF_F003;
            case (op)
                0, 1, 2, 3: begin
                    logic [35:0] w;
                    w = good_word(d);
                    if ($urandom_range(0, 7) == 0) w[35:32] = w[35:32] ^ 4'(1 << $urandom_range(0, 3));
                    io_op(1, up | 32'($urandom_range(0, 15) * 4), w);
                end
                4: io_op(0, up | 32'($urandom_range(0, 15) * 4), '0);
                5: io_op(0, up | 32'h44, '0);
                6: io_op(1, up | 32'h40, '0);
                7: head_update((m_head + $urandom_range(0, m_count())) % NE);
                8: ep_check($urandom_range(0, NW - 1));
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        io_op($urandom_range(0, 1) == 1, up | 32'(32'h48 + $urandom_range(0, 13) * 4), good_word(d));
                    else
                        io_op($urandom_range(0, 1) == 1, (up & 32'hFFFF_F07F) | 32'($urandom_range(1, 31) << 7), good_word(d));
                end
            endcase
            chk_ptrs();
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
